// File: rtl/pbkdf2_2_ctrl.sv
// rtl/pbkdf2_2_ctrl.sv - PBKDF2 second-pass sequencer; optional WAIT timeout via PBKDF2_2_CTRL_TIMEOUT_EN
module pbkdf2_2_ctrl #(
  parameter int SHA_TIMEOUT = 128,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sha256_digest_valid,
  output logic       sha256_init,
  output logic       sha256_first_block,
  output logic [1:0] sel_block_in,
  output logic [1:0] sel_prev_hash,
  output logic       update_mem_0,
  output logic       store_i_o_hash,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_B1_INIT = 4'd2,
    S_B1_WAIT = 4'd3,
    S_B2_INIT = 4'd4,
    S_B2_WAIT = 4'd5,
    S_B3_INIT = 4'd6,
    S_B3_WAIT = 4'd7,
    S_BO_INIT = 4'd8,
    S_BO_WAIT = 4'd9,
    S_FIN     = 4'd10
  } state_t;

  // The timeout counter must be able to hold SHA_TIMEOUT-1
  if (TW < 1 || SHA_TIMEOUT < 1 || SHA_TIMEOUT >= (2 ** TW)) begin : g_param_check
    $error("pbkdf2_2_ctrl: TW too narrow for SHA_TIMEOUT");
  end

  state_t state;
  logic   wait_first;
  logic   in_wait;
  logic   advance;
  logic   timeout_hit;

  // Decode whether the sequencer is waiting on a digest
  always_comb begin
    in_wait = 1'b0;
    case (state)
      S_B1_WAIT, S_B2_WAIT, S_B3_WAIT, S_BO_WAIT: in_wait = 1'b1;
      default:                                    in_wait = 1'b0;
    endcase
  end

  // The first WAIT cycle may still see the previous block's digest_valid
  assign advance = in_wait & ~wait_first & sha256_digest_valid;

  // Digest capture happens in the advancing cycle itself; the outer digest is never written back
  assign update_mem_0 = advance & ~reset & (state != S_BO_WAIT);

  // Every block chains a previous digest, so the core never starts from the IV
  assign sha256_first_block = 1'b0;

`ifdef PBKDF2_2_CTRL_TIMEOUT_EN
  logic [TW-1:0] to_cnt;

  // Counter holds the number of WAIT cycles already spent on the current block
  assign timeout_hit = in_wait & ~advance & (to_cnt == TW'(SHA_TIMEOUT - 1));

  // Clear while issuing a block, count while waiting on it
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (in_wait) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  // Sticky error flag, cleared only when a new job is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Job sequencer with registered strobes and mux selects
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_first     <= 1'b0;
      sha256_init    <= 1'b0;
      sel_block_in   <= 2'd0;
      sel_prev_hash  <= 2'd0;
      store_i_o_hash <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      sha256_init    <= 1'b0;
      store_i_o_hash <= 1'b0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_LOAD;
            store_i_o_hash <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_LOAD: begin
          state         <= S_B1_INIT;
          sha256_init   <= 1'b1;
          sel_block_in  <= 2'd0;
          sel_prev_hash <= 2'd0;
        end
        S_B1_INIT: begin
          state      <= S_B1_WAIT;
          wait_first <= 1'b1;
        end
        S_B2_INIT: begin
          state      <= S_B2_WAIT;
          wait_first <= 1'b1;
        end
        S_B3_INIT: begin
          state      <= S_B3_WAIT;
          wait_first <= 1'b1;
        end
        S_BO_INIT: begin
          state      <= S_BO_WAIT;
          wait_first <= 1'b1;
        end
        S_B1_WAIT: begin
          wait_first <= 1'b0;
          if (advance) begin
            state         <= S_B2_INIT;
            sha256_init   <= 1'b1;
            sel_block_in  <= 2'd1;
            sel_prev_hash <= 2'd1;
          end else if (timeout_hit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_B2_WAIT: begin
          wait_first <= 1'b0;
          if (advance) begin
            state         <= S_B3_INIT;
            sha256_init   <= 1'b1;
            sel_block_in  <= 2'd2;
            sel_prev_hash <= 2'd1;
          end else if (timeout_hit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_B3_WAIT: begin
          wait_first <= 1'b0;
          if (advance) begin
            state         <= S_BO_INIT;
            sha256_init   <= 1'b1;
            sel_block_in  <= 2'd3;
            sel_prev_hash <= 2'd2;
          end else if (timeout_hit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_BO_WAIT: begin
          wait_first <= 1'b0;
          if (advance) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else if (timeout_hit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
